// File: rtl/fwrisc_fetch_pkg.sv
// Shared types and defaults for the fwrisc instruction-fetch front end.
package fwrisc_fetch_pkg;

    localparam logic [31:0] FWRISC_RESET_VECTOR = 32'h8000_0000;

    typedef struct packed {
        logic        err;
        logic [29:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fwrisc_fetch_fifo.sv
// Generic DEPTH x WIDTH circular buffer with push/pop/flush and occupancy.
module fwrisc_fetch_fifo
    import fwrisc_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    // Storage is deliberately unreset; the consumer masks it while empty.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fwrisc_fetch_buf.sv
// Prefetch queue between the instruction bus and decode, with redirect flush.
// Optional perf counters (stall_cycles, flush_count) under FWRISC_FETCH_PERF_EN.
module fwrisc_fetch_buf
    import fwrisc_fetch_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = FWRISC_RESET_VECTOR,
    parameter bit          BYPASS       = 1'b0,
    localparam int         CW           = clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [31:0]   iaddr,
    output logic          ivalid,
    input  logic [31:0]   idata,
    input  logic          iready,
    input  logic          ierr,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_err,
    input  logic          instr_ready,
`ifdef FWRISC_FETCH_PERF_EN
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count,
`endif
    output logic [CW-1:0] count
);

    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;
    fetch_entry_t  head;
    logic [29:0]   fetch_pc;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          accept;
    logic          bypass_hit;
    logic          push;
    logic          pop;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Request depends only on occupancy, never on instr_ready.
    assign ivalid     = !reset && !redirect_valid && !q_full;
    assign accept     = ivalid && iready;
    assign iaddr      = {fetch_pc, 2'b00};
    assign wr_entry   = '{err: ierr, pc: fetch_pc, word: idata};
    assign bypass_hit = BYPASS && q_empty && accept;
    assign push       = accept && !(bypass_hit && instr_ready);
    assign pop        = !q_empty && instr_ready && !redirect_valid;

    assign instr_valid = !q_empty || bypass_hit;
    assign instr       = head.word;
    assign instr_pc    = {head.pc, 2'b00};
    assign instr_err   = head.err;
    assign count       = q_count;

    always_comb begin
        head = '0;
        unique case (1'b1)
            !q_empty:   head = rd_entry;
            bypass_hit: head = wr_entry;
            default:    head = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR[31:2];
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc[31:2];
        end else if (accept) begin
            fetch_pc <= fetch_pc + 30'd1;
        end
    end

    fwrisc_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

`ifdef FWRISC_FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (ivalid && !iready) stall_cycles <= stall_cycles + 32'd1;
            if (redirect_valid)    flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwrisc_fetch_buf.sv
// Self-checking bench: instance 0 without bypass, instance 1 with bypass.
module tb_fwrisc_fetch_buf;
    import fwrisc_fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = clog2(DEPTH + 1);

    logic          clock;
    logic          reset;
    logic [31:0]   idata;
    logic          iready;
    logic          ierr;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          instr_ready;
    logic [31:0]   iaddr       [2];
    logic          ivalid      [2];
    logic          instr_valid [2];
    logic [31:0]   instr       [2];
    logic [31:0]   instr_pc    [2];
    logic          instr_err   [2];
    logic [CW-1:0] count       [2];
`ifdef FWRISC_FETCH_PERF_EN
    logic [31:0]   stall_cycles [2];
    logic [31:0]   flush_count  [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fwrisc_fetch_buf #(.DEPTH(DEPTH), .BYPASS(1'b0)) u_dut0 (
        .clock          (clock),
        .reset          (reset),
        .iaddr          (iaddr[0]),
        .ivalid         (ivalid[0]),
        .idata          (idata),
        .iready         (iready),
        .ierr           (ierr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid[0]),
        .instr          (instr[0]),
        .instr_pc       (instr_pc[0]),
        .instr_err      (instr_err[0]),
        .instr_ready    (instr_ready),
`ifdef FWRISC_FETCH_PERF_EN
        .stall_cycles   (stall_cycles[0]),
        .flush_count    (flush_count[0]),
`endif
        .count          (count[0])
    );

    fwrisc_fetch_buf #(.DEPTH(DEPTH), .BYPASS(1'b1)) u_dut1 (
        .clock          (clock),
        .reset          (reset),
        .iaddr          (iaddr[1]),
        .ivalid         (ivalid[1]),
        .idata          (idata),
        .iready         (iready),
        .ierr           (ierr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid[1]),
        .instr          (instr[1]),
        .instr_pc       (instr_pc[1]),
        .instr_err      (instr_err[1]),
        .instr_ready    (instr_ready),
`ifdef FWRISC_FETCH_PERF_EN
        .stall_cycles   (stall_cycles[1]),
        .flush_count    (flush_count[1]),
`endif
        .count          (count[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                n_cmp++;
                if (count[b] > CW'(DEPTH)) begin
                    n_bad++;
                    $display("FAIL count_bound[%0d]: got %0d limit %0d", b, count[b], DEPTH);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        iready         = 1'b0;
        instr_ready    = 1'b0;
        ierr           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        idata          = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Behavioural reference: a plain queue per instance plus the fetch address.
    typedef struct packed {
        logic        err;
        logic [29:0] pc;
        logic [31:0] word;
    } m_t;

    m_t          mq0[$];
    m_t          mq1[$];
    logic [29:0] mf0;
    logic [29:0] mf1;

    task automatic model_cycle(input int b);
        m_t          q[$];
        m_t          h;
        logic [29:0] fpc;
        bit          iv;
        bit          acc;
        bit          ov;
        bit          eaten;
        if (b == 1) begin q = mq1; fpc = mf1; end
        else begin q = mq0; fpc = mf0; end
        iv  = !redirect_valid && (q.size() < DEPTH);
        acc = iv && iready;
        ov  = 1'b0;
        h   = '0;
        if (q.size() != 0) begin
            ov = 1'b1;
            h  = q[0];
        end else if (b == 1 && acc) begin
            ov = 1'b1;
            h  = '{err: ierr, pc: fpc, word: idata};
        end
        chk($sformatf("ivalid[%0d]", b), 64'(ivalid[b]), 64'(iv));
        chk($sformatf("iaddr[%0d]", b), 64'(iaddr[b]), 64'({fpc, 2'b00}));
        chk($sformatf("count[%0d]", b), 64'(count[b]), 64'(q.size()));
        chk($sformatf("instr_valid[%0d]", b), 64'(instr_valid[b]), 64'(ov));
        chk($sformatf("instr[%0d]", b), 64'(instr[b]), 64'(h.word));
        chk($sformatf("instr_pc[%0d]", b), 64'(instr_pc[b]), 64'({h.pc, 2'b00}));
        chk($sformatf("instr_err[%0d]", b), 64'(instr_err[b]), 64'(h.err));
        eaten = (b == 1) && (q.size() == 0) && instr_ready;
        if (redirect_valid) begin
            q.delete();
            fpc = redirect_pc[31:2];
        end else begin
            if (q.size() != 0 && instr_ready) void'(q.pop_front());
            if (acc && !eaten) q.push_back('{err: ierr, pc: fpc, word: idata});
            if (acc) fpc = fpc + 30'd1;
        end
        if (b == 1) begin mq1 = q; mf1 = fpc; end
        else begin mq0 = q; mf0 = fpc; end
    endtask

    typedef struct {
        bit          ir;
        bit          ird;
        logic [31:0] addr;
        bit          iv;
        bit          ov;
        logic [31:0] pc;
        int          cnt;
    } vec_t;

    vec_t vec[11];

    initial begin
        logic [31:0] exp_instr;

        vec[0]  = '{1, 1, 32'h8000_0000, 1, 0, 32'h0, 0};
        vec[1]  = '{1, 1, 32'h8000_0004, 1, 1, 32'h8000_0000, 1};
        vec[2]  = '{1, 1, 32'h8000_0008, 1, 1, 32'h8000_0004, 1};
        vec[3]  = '{1, 0, 32'h8000_000C, 1, 1, 32'h8000_0008, 1};
        vec[4]  = '{1, 0, 32'h8000_0010, 1, 1, 32'h8000_0008, 2};
        vec[5]  = '{1, 0, 32'h8000_0014, 1, 1, 32'h8000_0008, 3};
        vec[6]  = '{1, 0, 32'h8000_0018, 0, 1, 32'h8000_0008, 4};
        vec[7]  = '{1, 0, 32'h8000_0018, 0, 1, 32'h8000_0008, 4};
        vec[8]  = '{1, 1, 32'h8000_0018, 0, 1, 32'h8000_0008, 4};
        vec[9]  = '{1, 1, 32'h8000_0018, 1, 1, 32'h8000_000C, 3};
        vec[10] = '{1, 1, 32'h8000_001C, 1, 1, 32'h8000_0010, 3};

        // Reset state.
        reset = 1'b1;
        iready = 1'b1;
        instr_ready = 1'b1;
        ierr = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        idata = 32'h0000_0013;
        #3;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("rst_ivalid[%0d]", b), 64'(ivalid[b]), 64'd0);
            chk($sformatf("rst_instr_valid[%0d]", b), 64'(instr_valid[b]), 64'd0);
            chk($sformatf("rst_instr[%0d]", b), 64'(instr[b]), 64'd0);
            chk($sformatf("rst_count[%0d]", b), 64'(count[b]), 64'd0);
            chk($sformatf("rst_iaddr[%0d]", b), 64'(iaddr[b]), 64'h8000_0000);
        end

        // Streaming and backpressure table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            iready      = vec[i].ir;
            instr_ready = vec[i].ird;
            idata       = 32'hA000_0000 | 32'(i);
            #1;
            exp_instr = vec[i].ov ? (32'hA000_0000 | ((vec[i].pc - 32'h8000_0000) >> 2)) : 32'h0;
            chk($sformatf("tab_iaddr[%0d]", i), 64'(iaddr[0]), 64'(vec[i].addr));
            chk($sformatf("tab_ivalid[%0d]", i), 64'(ivalid[0]), 64'(vec[i].iv));
            chk($sformatf("tab_instr_valid[%0d]", i), 64'(instr_valid[0]), 64'(vec[i].ov));
            chk($sformatf("tab_instr_pc[%0d]", i), 64'(instr_pc[0]), 64'(vec[i].pc));
            chk($sformatf("tab_instr[%0d]", i), 64'(instr[0]), 64'(exp_instr));
            chk($sformatf("tab_count[%0d]", i), 64'(count[0]), 64'(vec[i].cnt));
        end

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            iready = 1'b1;
            idata  = 32'hB000_0000 | 32'(i);
        end
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        instr_ready    = 1'b1;
        #1;
        chk("redir_count_before", 64'(count[0]), 64'd3);
        chk("redir_ivalid", 64'(ivalid[0]), 64'd0);
        @(negedge clock);
        redirect_valid = 1'b0;
        idata          = 32'hC000_0100;
        #1;
        chk("redir_count", 64'(count[0]), 64'd0);
        chk("redir_instr_valid", 64'(instr_valid[0]), 64'd0);
        chk("redir_iaddr", 64'(iaddr[0]), 64'h8000_0100);
        chk("redir_ivalid_after", 64'(ivalid[0]), 64'd1);
        @(negedge clock);
        #1;
        chk("redir_first_pc", 64'(instr_pc[0]), 64'h8000_0100);
        chk("redir_first_word", 64'(instr[0]), 64'hC000_0100);

        // Bus error tagging on the third fetch.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            iready = 1'b1;
            ierr   = (i == 2);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            iready      = 1'b0;
            ierr        = 1'b0;
            instr_ready = 1'b1;
            #1;
            chk($sformatf("err_pc[%0d]", k), 64'(instr_pc[0]), 64'(32'h8000_0000 + 32'(4 * k)));
            chk($sformatf("err_flag[%0d]", k), 64'(instr_err[0]), 64'(k == 2));
        end

        // Empty-queue bypass.
        do_reset();
        @(negedge clock);
        iready      = 1'b1;
        instr_ready = 1'b1;
        idata       = 32'h0000_0013;
        #1;
        chk("byp_valid", 64'(instr_valid[1]), 64'd1);
        chk("byp_instr", 64'(instr[1]), 64'h0000_0013);
        chk("byp_pc", 64'(instr_pc[1]), 64'h8000_0000);
        chk("nobyp_valid", 64'(instr_valid[0]), 64'd0);
        @(negedge clock);
        #1;
        chk("byp_count", 64'(count[1]), 64'd0);
        chk("byp_pc_next", 64'(instr_pc[1]), 64'h8000_0004);
        chk("nobyp_valid_next", 64'(instr_valid[0]), 64'd1);

        // Async reset mid-stream.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            iready = 1'b1;
            idata  = 32'hD000_0000 | 32'(i);
        end
        @(negedge clock);
        #2;
        chk("ar_count_before", 64'(count[0]), 64'd2);
        reset = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("ar_ivalid[%0d]", b), 64'(ivalid[b]), 64'd0);
            chk($sformatf("ar_instr_valid[%0d]", b), 64'(instr_valid[b]), 64'd0);
            chk($sformatf("ar_instr[%0d]", b), 64'(instr[b]), 64'd0);
            chk($sformatf("ar_instr_pc[%0d]", b), 64'(instr_pc[b]), 64'd0);
            chk($sformatf("ar_instr_err[%0d]", b), 64'(instr_err[b]), 64'd0);
            chk($sformatf("ar_count[%0d]", b), 64'(count[b]), 64'd0);
        end
        @(negedge clock);
        reset  = 1'b0;
        iready = 1'b0;
        @(negedge clock);
        #1;
        chk("ar_iaddr", 64'(iaddr[0]), 64'h8000_0000);

`ifdef FWRISC_FETCH_PERF_EN
        do_reset();
        repeat (5) @(negedge clock);
        #1;
        chk("perf_stall", 64'(stall_cycles[0]), 64'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        repeat (2) @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        chk("perf_flush", 64'(flush_count[0]), 64'd2);
        chk("perf_stall_hold", 64'(stall_cycles[0]), 64'd5);
`endif

        // Randomized run against the queue model on both instances.
        do_reset();
        mq0.delete();
        mq1.delete();
        mf0 = FWRISC_RESET_VECTOR[31:2];
        mf1 = FWRISC_RESET_VECTOR[31:2];
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            iready         = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 9) < 6);
            ierr           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            idata          = $urandom;
            #1;
            model_cycle(0);
            model_cycle(1);
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
